// File: rtl/motorola_wb_bridge.sv
// Wishbone slave to Motorola 68000-style asynchronous bus master bridge.
// Each Wishbone transfer is split into 16-bit word cycles issued in ascending
// address order (big-endian lanes). Bus cycles end on _DTACK, on _BERR, after
// a timeout, or through the 6800-style _VPA/_VMA/E synchronous handshake.
module motorola_wb_bridge #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 64,
  parameter int E_DIV   = 10,
  parameter int E_HIGH  = 4
) (
  input  logic                       CLK,
  input  logic                       _RST,
  // Wishbone slave
  input  logic                       CYC_I,
  input  logic                       STB_I,
  input  logic                       WE_I,
  input  logic [24-$clog2(DW/8)-1:0] ADR_I,
  input  logic [DW-1:0]              DAT_I,
  input  logic [DW/8-1:0]            SEL_I,
  output logic [DW-1:0]              DAT_O,
  output logic                       ACK_O,
  output logic                       ERR_O,
  input  logic [2:0]                 fc_i,
  // Motorola master
  output logic [22:0]                A,
  input  logic [15:0]                D_I,
  output logic [15:0]                D_O,
  output logic                       D_OE,
  output logic                       _AS,
  output logic                       _UDS,
  output logic                       _LDS,
  output logic                       R_W,
  output logic [2:0]                 _FC,
  input  logic                       _DTACK,
  input  logic                       _BERR,
  input  logic                       _VPA,
  output logic                       _VMA,
  output logic                       E
);

  localparam int BW  = DW / 8;
  localparam int N   = DW / 16;
  localparam int KW  = $clog2(N);
  localparam int SW  = (KW == 0) ? 1 : KW;
  localparam int AW  = 24 - $clog2(BW);
  localparam int ECW = (E_DIV > 1) ? $clog2(E_DIV) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, VPA_SYNC, HOLD, DONE} state_t;

  typedef struct packed {
    logic          found;
    logic [SW-1:0] idx;
  } pick_t;

  state_t          state;
  logic [AW-1:0]   adr_q;
  logic            we_q;
  logic [BW-1:0]   sel_q;
  logic [DW-1:0]   dat_q;
  logic [2:0]      fc_q;
  logic [SW-1:0]   slot;
  logic [TW-1:0]   tmo_cnt;
  logic            vma_active;
  logic            err_q;
  logic            abort_q;
  logic [ECW-1:0]  e_cnt;
  logic [ECW-1:0]  e_nxt;
  logic            e_wrap;

  logic [BW-1:0]   cur_sel;
  logic [AW-1:0]   cur_adr;
  logic [DW-1:0]   cur_dat;
  logic            cur_we;
  logic [2:0]      cur_fc;
  int              from;
  pick_t           nxt;
  logic [22:0]     nxt_a;
  logic [15:0]     nxt_d;
  logic            cur_ub;
  logic            cur_lb;
  logic [DW-1:0]   dat_latched;
  logic            tmo_done;

  // Lowest slot index at or above 'start' that has at least one byte strobe set.
  function automatic pick_t pick_slot(input logic [BW-1:0] sel, input int start);
    pick_slot = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (k >= start && (sel[BW-1-2*k] || sel[BW-2-2*k])) begin
        pick_slot.found = 1'b1;
        pick_slot.idx   = SW'(k);
      end
    end
  endfunction

  // Next-slot selection: from the live Wishbone inputs on accept, else from the latched request.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    cur_sel     = sel_q;
    cur_adr     = adr_q;
    cur_dat     = dat_q;
    cur_we      = we_q;
    cur_fc      = fc_q;
    from        = int'(slot) + 1;
    nxt_d       = '0;
    cur_ub      = 1'b0;
    cur_lb      = 1'b0;
    dat_latched = DAT_O;
    if (state == IDLE) begin
      cur_sel = SEL_I;
      cur_adr = ADR_I;
      cur_dat = DAT_I;
      cur_we  = WE_I;
      cur_fc  = fc_i;
      from    = 0;
    end
    nxt   = pick_slot(cur_sel, from);
    nxt_a = (23'(cur_adr) << KW) | 23'(nxt.idx);
    for (int k = 0; k < N; k++) begin
      if (SW'(k) == nxt.idx) nxt_d = cur_dat[DW-1-16*k -: 16];
      if (SW'(k) == slot) begin
        cur_ub = sel_q[BW-1-2*k];
        cur_lb = sel_q[BW-2-2*k];
        dat_latched[DW-1-16*k -: 16] = D_I;
      end
    end
    tmo_done = (tmo_cnt == TW'(TIMEOUT - 1));
  end

  // E clock divider: free-running, low for the first E_DIV-E_HIGH counts of each period.
  always_comb begin
    e_wrap = (e_cnt == ECW'(E_DIV - 1));
    e_nxt  = e_wrap ? '0 : e_cnt + 1'b1;
  end

  // Registered E counter and E output.
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      e_cnt <= '0;
      E     <= 1'b0;
    end else begin
      e_cnt <= e_nxt;
      E     <= (e_nxt >= ECW'(E_DIV - E_HIGH));
    end
  end

  // Bridge FSM with all bus and Wishbone outputs registered.
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state      <= IDLE;
      adr_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      dat_q      <= '0;
      fc_q       <= '0;
      slot       <= '0;
      tmo_cnt    <= '0;
      vma_active <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
      A          <= '0;
      D_O        <= '0;
      D_OE       <= 1'b0;
      _AS        <= 1'b1;
      _UDS       <= 1'b1;
      _LDS       <= 1'b1;
      R_W        <= 1'b1;
      _FC        <= 3'b111;
      _VMA       <= 1'b1;
      DAT_O      <= '0;
      ACK_O      <= 1'b0;
      ERR_O      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
      if (state != IDLE && !CYC_I) abort_q <= 1'b1;
      case (state)
        IDLE: begin
          // Hold off a new accept while the previous ACK/ERR is still visible to the master.
          if (CYC_I && STB_I && !ACK_O && !ERR_O) begin
            adr_q   <= ADR_I;
            we_q    <= WE_I;
            sel_q   <= SEL_I;
            dat_q   <= DAT_I;
            fc_q    <= fc_i;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            if (nxt.found) begin
              slot  <= nxt.idx;
              A     <= nxt_a;
              R_W   <= !cur_we;
              _FC   <= ~cur_fc;
              if (cur_we) D_O <= nxt_d;
              D_OE  <= cur_we;
              state <= SETUP;
            end else begin
              state <= DONE;
            end
          end
        end
        SETUP: begin
          _AS     <= 1'b0;
          _UDS    <= !cur_ub;
          _LDS    <= !cur_lb;
          tmo_cnt <= '0;
          state   <= STROBE;
        end
        STROBE: begin
          if (!_BERR || (_DTACK && _VPA && tmo_done)) begin
            err_q <= 1'b1;
            _AS   <= 1'b1;
            _UDS  <= 1'b1;
            _LDS  <= 1'b1;
            D_OE  <= 1'b0;
            state <= HOLD;
          end else if (!_DTACK) begin
            if (!we_q) DAT_O <= dat_latched;
            _AS   <= 1'b1;
            _UDS  <= 1'b1;
            _LDS  <= 1'b1;
            D_OE  <= 1'b0;
            state <= HOLD;
          end else if (!_VPA) begin
            vma_active <= 1'b0;
            state      <= VPA_SYNC;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        VPA_SYNC: begin
          // _VMA falls with E at a low-phase start and data is taken at the following E fall.
          if (!_BERR || (e_wrap && vma_active)) begin
            if (_BERR && !we_q) DAT_O <= dat_latched;
            if (!_BERR) err_q <= 1'b1;
            _AS   <= 1'b1;
            _UDS  <= 1'b1;
            _LDS  <= 1'b1;
            _VMA  <= 1'b1;
            D_OE  <= 1'b0;
            state <= HOLD;
          end else if (e_wrap) begin
            vma_active <= 1'b1;
            _VMA       <= 1'b0;
          end
        end
        HOLD: begin
          if (abort_q || !CYC_I) begin
            state <= IDLE;
          end else if (!err_q && nxt.found) begin
            slot  <= nxt.idx;
            A     <= nxt_a;
            R_W   <= !cur_we;
            _FC   <= ~cur_fc;
            if (cur_we) D_O <= nxt_d;
            D_OE  <= cur_we;
            state <= SETUP;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          if (CYC_I && !abort_q) begin
            ACK_O <= !err_q;
            ERR_O <= err_q;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/motorola_wb_bridge.md
MOTOROLA_WB_BRIDGE -- requirements
Module: motorola_wb_bridge

Interface
REQ-001 SHALL have parameter DW, default 32, Wishbone data width; legal values 16, 32 or 64.
REQ-002 SHALL have parameter TIMEOUT, default 64, CLK cycles in STROBE with no _DTACK/_VPA/_BERR before the transfer is aborted.
REQ-003 SHALL have parameter E_DIV, default 10, E period in CLK cycles, and parameter E_HIGH, default 4, the number of E-high cycles per period.
REQ-004 SHALL use one clock and an asynchronous active-low reset: CLK in 1, rising-edge clock; _RST in 1, asynchronous active-low reset.
REQ-005 Wishbone slave ports: CYC_I in 1; STB_I in 1; WE_I in 1; ADR_I in 24-log2(DW/8) bits, the DW-aligned address [23:log2(DW/8)]; DAT_I in DW; SEL_I in DW/8; DAT_O out DW; ACK_O out 1; ERR_O out 1; fc_i in 3, function code.
REQ-006 Motorola master ports: A out 23, A[23:1]; D_I in 16; D_O out 16; D_OE out 1, data drive enable; _AS out 1; _UDS out 1; _LDS out 1; R_W out 1; _FC out 3; _DTACK in 1; _BERR in 1; _VPA in 1; _VMA out 1; E out 1.

Function
REQ-007 SHALL split each Wishbone transfer into N=DW/16 word slots k=0..N-1, issued in ascending address order; slot k SHALL use A = {ADR_I, k}.
REQ-008 Slot k mapping (big-endian): data DAT[DW-1-16k : DW-16-16k]; _UDS driven from SEL_I[DW/8-1-2k], _LDS from SEL_I[DW/8-2-2k], both active-low.
REQ-009 Slots with both strobe bits zero SHALL be skipped (no bus cycle); a transfer with SEL_I all zero SHALL ACK on the next edge with no bus cycle.
REQ-010 FSM states: IDLE, SETUP, STROBE, VPA_SYNC, HOLD, DONE.
REQ-011 IDLE -> SETUP when CYC_I&STB_I, on the accept edge; ADR_I, WE_I, SEL_I, DAT_I and fc_i SHALL be latched at that edge.
REQ-012 SETUP, 1 cycle: drive A, R_W = !WE, _FC = ~fc; if writing, drive D_O and set D_OE=1; -> STROBE.
REQ-013 STROBE: _AS plus the selected _UDS/_LDS low; sample each cycle with priority _BERR, then _DTACK, then _VPA, then timeout.
REQ-014 _DTACK low in STROBE SHALL latch D_I into the slot's DAT_O lanes (reads only) and go -> HOLD.
REQ-015 _VPA low in STROBE -> VPA_SYNC: assert _VMA low at the next E-low phase start, hold until the E falling edge, then latch data -> HOLD.
REQ-016 HOLD, 1 cycle: _AS, _UDS, _LDS and _VMA high, D_OE=0; then -> SETUP of the next non-skipped slot, else -> DONE.
REQ-017 DONE: ACK_O high for exactly one cycle, then -> IDLE; ACK_O and ERR_O SHALL never be high together.
REQ-018 _BERR low, or TIMEOUT cycles elapsed in STROBE, SHALL negate the strobes via HOLD, skip the remaining slots and pulse ERR_O for one cycle instead of ACK_O.
REQ-019 CYC_I dropped mid-transfer SHALL let the current bus cycle finish through HOLD, then -> IDLE with no ACK_O/ERR_O.
REQ-020 E SHALL be a free-running counter modulo E_DIV, high for the last E_HIGH counts, independent of transfers.
REQ-021 Zero-wait latency: for n issued slots, ACK_O SHALL rise on the (3n+1)th rising edge after the accept edge.
REQ-022 DAT_O lanes of skipped or unfinished slots SHALL hold their previous values.

Reset
REQ-023 While _RST is low, all outputs SHALL be: _AS=_UDS=_LDS=_VMA=1, R_W=1, D_OE=0, D_O=0, A=0, _FC=3'b111, E=0, ACK_O=ERR_O=0, DAT_O=0; FSM=IDLE; E counter=0.
REQ-024 _RST asserted mid-transfer SHALL immediately negate all strobes without ACK; the first transfer after release SHALL start from IDLE.

Verification
REQ-025 DW=32 read, SEL=4'hF, ADR=0x100, _DTACK tied low, D_I=0x1234 then 0x5678 -> A=0x080 then 0x081, DAT_O=0x12345678, ACK_O on edge 7.
REQ-026 DW=32 write, SEL=4'b0011, DAT_I=0xAABBCCDD -> exactly one bus cycle at slot 1, D_O=0xCCDD, _UDS=_LDS=0, R_W=0, ACK on edge 4.
REQ-027 _DTACK never asserted, TIMEOUT=64 -> _AS low for 64 cycles, then negated; ERR_O pulses once; ACK_O stays 0.
REQ-028 _VPA low in slot 0, E_DIV=10 -> _VMA low only in the E-low phase, data latched at E fall, E keeps its 6-low/4-high pattern.
REQ-029 DW=64, _BERR low during slot 1 -> slots 2-3 not issued, ERR_O pulse; SEL=0 -> ACK on the next edge with _AS never low.
REQ-030 _RST pulsed low mid-STROBE -> _AS high asynchronously, no ACK; the next transfer completes normally.
